// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter running on the audio PLL clock.
// Derives BCLK/LRCLK from clk and serialises stereo pairs from a valid/ready stream.
module audio_i2s_tx #(
   parameter int DATA_W   = 24,
   parameter int BCLK_DIV = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_sdata,
   output logic              underrun
);
   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2 - 1);
   localparam int PAD = 31 - DATA_W;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic w_enter;
   logic w_active;

   logic r_lock_meta;
   logic r_lock_s;

   logic [DIV_W-1:0]  r_div;
   logic [5:0]        r_bit;
   logic              r_bclk;
   logic              r_lrclk;
   logic              r_sdata;
   logic              r_underrun;
   logic              r_ready;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_hold_l;
   logic [DATA_W-1:0] r_hold_r;
   logic [63:0]       r_frame;

   logic        w_fall;
   logic        w_rise;
   logic [5:0]  w_bit_nxt;
   logic        w_load;
   logic        w_xfer;
   logic        w_hold_nxt;
   logic [31:0] w_lw;
   logic [31:0] w_rw;
   logic [63:0] w_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (r_lock_s)  w_state_nxt = RUN;
         RUN:     if (!r_lock_s) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_enter  = 1'b0;
      w_active = 1'b0;
      case (r_state)
         IDLE:    w_enter  = (w_state_nxt == RUN);
         RUN:     w_active = (w_state_nxt == RUN);
         default: ;
      endcase
   end

   assign w_fall     = (r_div == DIV_MAX);
   assign w_rise     = (r_div == DIV_HALF);
   assign w_bit_nxt  = r_bit + 6'd1;
   assign w_load     = w_fall && (r_bit == 6'd63);
   assign w_xfer     = s_valid && r_ready;
   assign w_hold_nxt = (r_hold_full && !w_load) || w_xfer;

   // Frame image: bit 63-b is what goes out in bit period b.
   assign w_lw   = 32'(r_hold_l) << PAD;
   assign w_rw   = 32'(r_hold_r) << PAD;
   assign w_word = r_hold_full ? {w_lw, w_rw} : 64'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div       <= '0;
         r_bit       <= '0;
         r_bclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_underrun  <= 1'b0;
         r_ready     <= 1'b0;
         r_hold_full <= 1'b0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_frame     <= '0;
      end else if (w_enter) begin
         r_div   <= '0;
         r_bit   <= 6'd63;
         r_bclk  <= 1'b0;
         r_ready <= 1'b1;
      end else if (w_active) begin
         r_underrun  <= 1'b0;
         r_hold_full <= w_hold_nxt;
         r_ready     <= !w_hold_nxt;
         if (w_xfer) begin
            r_hold_l <= s_left;
            r_hold_r <= s_right;
         end
         r_div <= w_fall ? '0 : r_div + 1'b1;
         if (w_rise) r_bclk <= 1'b1;
         if (w_fall) begin
            r_bclk  <= 1'b0;
            r_bit   <= w_bit_nxt;
            r_lrclk <= w_bit_nxt[5];
            if (w_load) begin
               r_sdata    <= w_word[63];
               r_frame    <= {w_word[62:0], 1'b0};
               r_underrun <= !r_hold_full;
            end else begin
               r_sdata <= r_frame[63];
               r_frame <= {r_frame[62:0], 1'b0};
            end
         end
      end else begin
         // Idle or losing lock: drop everything, stale pairs included.
         r_div       <= '0;
         r_bit       <= '0;
         r_bclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_underrun  <= 1'b0;
         r_ready     <= 1'b0;
         r_hold_full <= 1'b0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_frame     <= '0;
      end
   end

   assign s_ready   = r_ready;
   assign i2s_bclk  = r_bclk;
   assign i2s_lrclk = r_lrclk;
   assign i2s_sdata = r_sdata;
   assign underrun  = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for the I2S transmitter.
// Scenario tasks run in sequence and compare against hand-derived values.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          pll_locked;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_left;
   logic [DW-1:0] s_right;
   logic          i2s_bclk;
   logic          i2s_lrclk;
   logic          i2s_sdata;
   logic          underrun;

   int total = 0;
   int bad   = 0;

   audio_i2s_tx #(.DATA_W(DW), .BCLK_DIV(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_left     (s_left),
      .s_right    (s_right),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrclk  (i2s_lrclk),
      .i2s_sdata  (i2s_sdata),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_frame(input logic [DW-1:0] l,
                                             input logic [DW-1:0] r);
      logic [63:0] f;
      f = '0;
      for (int b = 0; b < 64; b++) begin
         if (b >= 1 && b <= DW) f[63-b] = l[DW-b];
         else if (b >= 33 && b <= 32 + DW) f[63-b] = r[32+DW-b];
      end
      return f;
   endfunction

   task automatic wait_lr_fall(output bit ok);
      logic prev;
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         prev = i2s_lrclk;
         tick(1);
         if (prev && !i2s_lrclk) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic capture64(output logic [63:0] f, output bit ok);
      logic prev;
      int k;
      f = '0;
      k = 0;
      for (int i = 0; i < 500 && k < 64; i++) begin
         prev = i2s_bclk;
         tick(1);
         if (!prev && i2s_bclk) begin
            f[63-k] = i2s_sdata;
            k++;
         end
      end
      ok = (k == 64);
   endtask

   task automatic test_reset;
      rst = 1'b1; pll_locked = 1'b1; s_valid = 1'b0;
      s_left = '0; s_right = '0;
      tick(4);
      total++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=00000",
                  {i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready});
      end
      rst = 1'b0;
      tick(3);
      total++;
      if (s_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset got=%b want=1", s_ready);
      end
   endtask

   task automatic test_bclk;
      logic prev;
      bit found;
      int hi, lo;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         prev = i2s_bclk;
         tick(1);
         if (!prev && i2s_bclk) begin
            found = 1'b1;
            break;
         end
      end
      hi = 0;
      while (i2s_bclk && hi < 20) begin tick(1); hi++; end
      lo = 0;
      while (!i2s_bclk && lo < 20) begin tick(1); lo++; end
      total++;
      if (!found) begin bad++; $display("FAIL bclk_rise got=none want=rise"); end
      total++;
      if (hi !== 3) begin bad++; $display("FAIL bclk_high got=%0d want=3", hi); end
      total++;
      if (lo !== 3) begin bad++; $display("FAIL bclk_low got=%0d want=3", lo); end
   endtask

   task automatic test_lrclk;
      bit ok;
      int lo, hi;
      wait_lr_fall(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL lrclk_fall got=timeout want=fall"); end
      lo = 0;
      while (!i2s_lrclk && lo < 400) begin tick(1); lo++; end
      hi = 0;
      while (i2s_lrclk && hi < 400) begin tick(1); hi++; end
      total++;
      if (lo !== 192) begin bad++; $display("FAIL lrclk_low got=%0d want=192", lo); end
      total++;
      if (lo + hi !== 384) begin bad++; $display("FAIL lrclk_period got=%0d want=384", lo + hi); end
      total++;
      if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_idle_frame got=%b want=1", underrun); end
   endtask

   task automatic test_frame;
      bit ok, ok2;
      logic [63:0] f;
      s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h5A5A5A;
      tick(1);
      s_valid = 1'b0;
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b want=0", s_ready); end
      wait_lr_fall(ok);
      total++;
      if (!ok || underrun !== 1'b0) begin
         bad++; $display("FAIL frame_load_underrun got=%b ok=%0d want=0", underrun, ok);
      end
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_load got=%b want=1", s_ready); end
      capture64(f, ok2);
      total++;
      if (!ok2 || f !== {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00}) begin
         bad++;
         $display("FAIL frame_a5 got=%h want=%h", f, {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00});
      end
   endtask

   task automatic test_underrun;
      bit found;
      int cnt, pos_bad, ones;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (underrun) begin found = 1'b1; break; end
      end
      cnt = 0; pos_bad = 0; ones = 0;
      for (int i = 1; i <= 1152; i++) begin
         tick(1);
         if (underrun) begin
            cnt++;
            if (i % 384 != 0) pos_bad++;
         end
         if (i2s_sdata) ones++;
      end
      total++;
      if (!found) begin bad++; $display("FAIL underrun_first got=none want=pulse"); end
      total++;
      if (cnt !== 3) begin bad++; $display("FAIL underrun_count got=%0d want=3", cnt); end
      total++;
      if (pos_bad !== 0) begin bad++; $display("FAIL underrun_spacing got=%0d off want=0", pos_bad); end
      total++;
      if (ones !== 0) begin bad++; $display("FAIL idle_sdata got=%0d ones want=0", ones); end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] ql[$];
      logic [DW-1:0] qr[$];
      logic [DW-1:0] el, er;
      logic [63:0] f;
      logic xf, pb, pl;
      int p, last_x, cyc, starts, k;
      p = 0; last_x = -1; cyc = 0; starts = 0; k = 0; f = '0;
      s_valid = 1'b1;
      s_left = 24'h100000; s_right = 24'hE00000;
      while (starts < 5 && cyc < 2400) begin
         xf = s_ready; pb = i2s_bclk; pl = i2s_lrclk;
         tick(1);
         cyc++;
         if (xf) begin
            if (last_x >= 0) begin
               total++;
               if (cyc - last_x !== 384) begin
                  bad++; $display("FAIL b2b_interval got=%0d want=384", cyc - last_x);
               end
            end
            last_x = cyc;
            ql.push_back(s_left); qr.push_back(s_right);
            p++;
            s_left = 24'h100000 + 24'(p);
            s_right = 24'hE00000 - 24'(p);
         end
         if (pl && !i2s_lrclk) begin
            if (starts > 0) begin
               el = '0; er = '0;
               if (ql.size() > 0) begin el = ql.pop_front(); er = qr.pop_front(); end
               total++;
               if (k !== 64 || f !== exp_frame(el, er)) begin
                  bad++; $display("FAIL b2b_frame%0d got=%h want=%h", starts, f, exp_frame(el, er));
               end
            end
            total++;
            if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun got=%b want=0", underrun); end
            starts++; k = 0; f = '0;
         end else if (!pb && i2s_bclk && k < 64) begin
            f[63-k] = i2s_sdata;
            k++;
         end
      end
      s_valid = 1'b0;
      total++;
      if (starts !== 5) begin bad++; $display("FAIL b2b_frames got=%0d want=5", starts); end
   endtask

   task automatic test_simul;
      bit ok;
      logic [63:0] f;
      tick(383);
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b want=1", s_ready); end
      s_valid = 1'b1; s_left = 24'h123456; s_right = 24'hFEDCBA;
      tick(1);
      s_valid = 1'b0;
      total++;
      if (underrun !== 1'b1) begin bad++; $display("FAIL simul_underrun got=%b want=1", underrun); end
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL simul_hold got=%b want=0", s_ready); end
      capture64(f, ok);
      total++;
      if (!ok || f !== 64'd0) begin bad++; $display("FAIL simul_zero_frame got=%h want=0", f); end
      wait_lr_fall(ok);
      capture64(f, ok);
      total++;
      if (!ok || f !== exp_frame(24'h123456, 24'hFEDCBA)) begin
         bad++; $display("FAIL simul_next_frame got=%h want=%h", f, exp_frame(24'h123456, 24'hFEDCBA));
      end
   endtask

   task automatic test_unlock;
      bit ok;
      logic prev;
      logic [63:0] f;
      wait_lr_fall(ok);
      s_valid = 1'b1; s_left = 24'h777777; s_right = 24'h333333;
      tick(1);
      s_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         prev = i2s_lrclk;
         tick(1);
         if (!prev && i2s_lrclk) break;
      end
      tick(48);
      pll_locked = 1'b0;
      tick(3);
      total++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready} !== 5'b0) begin
         bad++;
         $display("FAIL unlock_outputs got=%b want=00000",
                  {i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready});
      end
      tick(5);
      pll_locked = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (s_ready) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL relock_ready got=0 want=1"); end
      tick(6);
      total++;
      if (underrun !== 1'b1) begin bad++; $display("FAIL relock_underrun got=%b want=1", underrun); end
      capture64(f, ok);
      total++;
      if (!ok || f !== 64'd0) begin bad++; $display("FAIL relock_stale got=%h want=0", f); end
   endtask

   task automatic test_async_reset;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (i2s_bclk && i2s_lrclk) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL async_setup got=timeout want=bclk_lrclk_high"); end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready} !== 5'b0) begin
         bad++;
         $display("FAIL async_reset got=%b want=00000",
                  {i2s_bclk, i2s_lrclk, i2s_sdata, underrun, s_ready});
      end
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      test_reset;
      test_bclk;
      test_lrclk;
      test_frame;
      test_underrun;
      test_back_to_back;
      test_simul;
      test_unlock;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
